// File: rtl/simd_pkg.sv
// Shared defaults and drain FSM encoding for the SIMD result path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package simd_pkg;

    localparam int SIMD_DATA_WIDTH  = 32;
    localparam int SIMD_PE_ELEMENTS = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_SEND     = 3'd3,
        ST_FINISH   = 3'd4,
        ST_CHECKSUM = 3'd5
    } drain_state_t;

    // Width of an index over n items; never zero so single-element rows still get a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/result_drain_if.sv
// Valid/ready word stream leaving the result drain.
// Latency: n/a (wires only).
// Backpressure: master holds m_data/m_valid/m_last while m_valid && !m_ready.
interface result_drain_if import simd_pkg::*; #(
    parameter int DATA_WIDTH = SIMD_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/result_drain_row_serializer.sv
// Holds one captured result row and streams its elements, element 0 first.
// Latency: first element valid the cycle after i_load; one element per accepted cycle.
// Backpressure: element index and output word freeze while o_valid && !i_ready.
module row_serializer import simd_pkg::*; #(
    parameter int DATA_WIDTH  = SIMD_DATA_WIDTH,
    parameter int PE_ELEMENTS = SIMD_PE_ELEMENTS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_load,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] i_row,
    input  logic                              i_last_row,
    input  logic                              i_ready,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic                              o_valid,
    output logic                              o_last,
    output logic                              o_row_done
);
    localparam int                 IDX_W    = idx_width(PE_ELEMENTS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(PE_ELEMENTS - 1);

    logic [DATA_WIDTH-1:0] r_buf [PE_ELEMENTS];
    logic [IDX_W-1:0]      r_idx;
    logic                  r_valid;
    logic                  r_last_row;

    logic w_accept;
    logic w_at_last;

    assign w_accept  = r_valid & i_ready;
    assign w_at_last = (r_idx == LAST_IDX);

    // Capture a full row on load, then step the element index on each accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < PE_ELEMENTS; e++) r_buf[e] <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_last_row <= 1'b0;
        end else if (i_load) begin
            for (int e = 0; e < PE_ELEMENTS; e++) r_buf[e] <= i_row[e*DATA_WIDTH +: DATA_WIDTH];
            r_idx      <= '0;
            r_valid    <= 1'b1;
            r_last_row <= i_last_row;
        end else if (w_accept) begin
            if (w_at_last) r_valid <= 1'b0;
            else           r_idx   <= r_idx + IDX_W'(1);
        end
    end

    assign o_data     = r_buf[r_idx];
    assign o_valid    = r_valid;
    assign o_last     = r_valid & r_last_row & w_at_last;
    assign o_row_done = w_accept & w_at_last;

endmodule

// File: rtl/result_drain.sv
// Drains rows from the result RAM and streams them out element by element.
// Latency: PE_ELEMENTS+2 cycles per row at full throughput; done one cycle after the final word.
// Backpressure: m_ready low stalls the current word; RAM reads wait until the row is sent.
// Optional: define RESULT_DRAIN_CHECKSUM_EN to append a modulo-2^DATA_WIDTH sum word carrying m_last.
module result_drain import simd_pkg::*; #(
    parameter int DATA_WIDTH      = SIMD_DATA_WIDTH,
    parameter int PE_ELEMENTS     = SIMD_PE_ELEMENTS,
    parameter int DRAM_DEPTH      = 256,
    parameter int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DRAM_ADDR_WIDTH-1:0]        base_addr,
    input  logic [DRAM_ADDR_WIDTH:0]          row_count,
    output logic [DRAM_ADDR_WIDTH-1:0]        ram_result_read_addr,
    output logic                              ram_result_rd_en,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] ram_result_read_data,
    result_drain_if.master                    m_if,
    output logic                              busy,
    output logic                              done
);
    localparam logic [DRAM_ADDR_WIDTH:0]   ONE_ROW   = 1;
    localparam logic [DRAM_ADDR_WIDTH-1:0] ONE_ADDR  = 1;
    localparam logic [DRAM_ADDR_WIDTH-1:0] LAST_ADDR = DRAM_ADDR_WIDTH'(DRAM_DEPTH - 1);
`ifdef RESULT_DRAIN_CHECKSUM_EN
    localparam drain_state_t TAIL_STATE = ST_CHECKSUM;
`else
    localparam drain_state_t TAIL_STATE = ST_FINISH;
`endif

    drain_state_t               r_state;
    logic [DRAM_ADDR_WIDTH-1:0] r_addr;
    logic [DRAM_ADDR_WIDTH:0]   r_rows;

    logic [DATA_WIDTH-1:0]      w_ser_dat;
    logic                       w_ser_vld;
    logic                       w_ser_last;
    logic                       w_row_done;
    logic                       w_final_row;
    logic                       w_last_row;
    logic [DRAM_ADDR_WIDTH-1:0] w_next_addr;

    assign w_final_row = (r_rows == ONE_ROW);
    assign w_next_addr = (r_addr == LAST_ADDR) ? '0 : r_addr + ONE_ADDR;
`ifdef RESULT_DRAIN_CHECKSUM_EN
    assign w_last_row  = 1'b0;   // the checksum word carries m_last instead
`else
    assign w_last_row  = w_final_row;
`endif

    // Drain sequencing: read a row, capture it, stream it, repeat until the row count is exhausted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_rows  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (row_count != '0) begin
                            r_addr  <= base_addr;
                            r_rows  <= row_count;
                            r_state <= ST_READ;
                        end else begin
                            r_state <= TAIL_STATE;
                        end
                    end
                end
                ST_READ:    r_state <= ST_CAPTURE;
                ST_CAPTURE: r_state <= ST_SEND;
                ST_SEND: begin
                    if (w_row_done) begin
                        r_rows  <= r_rows - ONE_ROW;
                        r_addr  <= w_next_addr;
                        r_state <= w_final_row ? TAIL_STATE : ST_READ;
                    end
                end
`ifdef RESULT_DRAIN_CHECKSUM_EN
                ST_CHECKSUM: if (m_if.m_ready) r_state <= ST_FINISH;
`endif
                ST_FINISH:  r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    row_serializer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PE_ELEMENTS (PE_ELEMENTS)
    ) u_ser (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_state == ST_CAPTURE),
        .i_row      (ram_result_read_data),
        .i_last_row (w_last_row),
        .i_ready    (m_if.m_ready),
        .o_data     (w_ser_dat),
        .o_valid    (w_ser_vld),
        .o_last     (w_ser_last),
        .o_row_done (w_row_done)
    );

`ifdef RESULT_DRAIN_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  w_in_cksum;

    assign w_in_cksum = (r_state == ST_CHECKSUM);

    // Running sum of every accepted data word, cleared when a new drain is accepted.
    always_ff @(posedge clk) begin
        if (rst)                              r_sum <= '0;
        else if (r_state == ST_IDLE && start) r_sum <= '0;
        else if (w_ser_vld && m_if.m_ready)   r_sum <= r_sum + w_ser_dat;
    end

    assign m_if.m_data  = w_in_cksum ? r_sum : w_ser_dat;
    assign m_if.m_valid = w_ser_vld | w_in_cksum;
    assign m_if.m_last  = w_ser_last | w_in_cksum;
`else
    assign m_if.m_data  = w_ser_dat;
    assign m_if.m_valid = w_ser_vld;
    assign m_if.m_last  = w_ser_last;
`endif

    assign ram_result_read_addr = r_addr;
    assign ram_result_rd_en     = (r_state == ST_READ);
    assign busy                 = (r_state != ST_IDLE);
    assign done                 = (r_state == ST_FINISH);

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: reset values, single row, empty drain, address wrap,
// stalls with an ignored start, reset mid-drain with start priority, two-row sum case.
// Expected words, cycles and addresses are hand-derived constants.
module tb_result_drain;
    import simd_pkg::*;

    localparam int DW = 32, PE = 4, DEPTH = 256, AW = 8;
`ifdef RESULT_DRAIN_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start;
    logic [AW-1:0]   base_addr;
    logic [AW:0]     row_count;
    logic [AW-1:0]   rd_addr;
    logic            rd_en;
    logic [PE*DW-1:0] rd_data;
    logic            busy, done;

    result_drain_if #(.DATA_WIDTH(DW)) m_if ();

    result_drain #(
        .DATA_WIDTH(DW), .PE_ELEMENTS(PE), .DRAM_DEPTH(DEPTH), .DRAM_ADDR_WIDTH(AW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .base_addr            (base_addr),
        .row_count            (row_count),
        .ram_result_read_addr (rd_addr),
        .ram_result_rd_en     (rd_en),
        .ram_result_read_data (rd_data),
        .m_if                 (m_if),
        .busy                 (busy),
        .done                 (done)
    );

    // Result RAM model, one-cycle read latency
    logic [PE*DW-1:0] mem [DEPTH];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] got_dat[$];
    logic          got_last[$];
    int            got_cyc[$];
    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] stall_dat[$];
    int            done_cyc[$];
    logic [DW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (m_if.m_valid && m_if.m_ready) begin
            got_dat.push_back(m_if.m_data);
            got_last.push_back(m_if.m_last);
            got_cyc.push_back(cyc);
        end
        if (m_if.m_valid && !m_if.m_ready) stall_dat.push_back(m_if.m_data);
        if (rd_en) got_addr.push_back(rd_addr);
        if (done) done_cyc.push_back(cyc);
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_dat.delete(); got_last.delete(); got_cyc.delete();
        got_addr.delete(); stall_dat.delete(); done_cyc.delete();
    endtask

    task automatic add_cksum();
`ifdef RESULT_DRAIN_CHECKSUM_EN
        logic [DW-1:0] s = '0;
        foreach (exp_q[i]) s += exp_q[i];
        exp_q.push_back(s);
`endif
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] n, output int k);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; row_count = n;
        k = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        logic seen = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
        @(posedge clk); #1;
        chk({tag, "_idle_after"}, busy, 1'b0);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_nwords"}, got_dat.size(), exp_q.size());
        for (int i = 0; i < got_dat.size() && i < exp_q.size(); i++) begin
            chk({tag, "_data"}, got_dat[i], exp_q[i]);
            chk({tag, "_last"}, got_last[i], (i == exp_q.size() - 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; base_addr = '0; row_count = '0;
        m_if.m_ready = 1'b1;
        mem[0]   = {32'd4, 32'd3, 32'd2, 32'd1};
        mem[1]   = {32'h44, 32'h33, 32'h22, 32'h11};
        mem[10]  = {32'd104, 32'd103, 32'd102, 32'd101};
        mem[11]  = {32'd114, 32'd113, 32'd112, 32'd111};
        mem[12]  = {32'd124, 32'd123, 32'd122, 32'd121};
        mem[20]  = {32'd204, 32'd203, 32'd202, 32'd201};
        mem[30]  = {32'd4, 32'd3, 32'd2, 32'd1};
        mem[31]  = {32'd8, 32'd7, 32'd6, 32'd5};
        mem[255] = {32'd14, 32'd13, 32'd12, 32'd11};

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_if.m_valid, 1'b0);
        chk("rst_m_last",  m_if.m_last,  1'b0);
        chk("rst_m_data",  m_if.m_data,  32'd0);
        chk("rst_rd_en",   rd_en,        1'b0);
        chk("rst_rd_addr", rd_addr,      8'd0);
        chk("rst_busy",    busy,         1'b0);
        chk("rst_done",    done,         1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // single row, full throughput: words in consecutive cycles, done right after the last
        clear_mon();
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        add_cksum();
        pulse_start(8'd0, 9'd1, k);
        chk("t1_busy", busy, 1'b1);
        wait_done("t1", 40);
        check_stream("t1");
        for (int i = 0; i < got_cyc.size(); i++) chk("t1_cyc", got_cyc[i], k + 3 + i);
        chk("t1_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, k + 3 + exp_q.size());
        chk("t1_done_len", done_cyc.size(), 1);
        chk("t1_nreads", got_addr.size(), 1);

        // empty drain: no data words, done in the cycle after start is taken
        clear_mon();
        exp_q.delete();
        add_cksum();
        pulse_start(8'd7, 9'd0, k);
        wait_done("t2", 20);
        check_stream("t2");
        chk("t2_nreads", got_addr.size(), 0);
        chk("t2_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, k + 1 + CK);

        // address wrap from the top row back to row 0
        clear_mon();
        exp_q = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd1, 32'd2, 32'd3, 32'd4};
        add_cksum();
        pulse_start(8'd255, 9'd2, k);
        wait_done("t3", 60);
        check_stream("t3");
        chk("t3_nreads", got_addr.size(), 2);
        if (got_addr.size() == 2) begin
            chk("t3_addr0", got_addr[0], 8'd255);
            chk("t3_addr1", got_addr[1], 8'd0);
        end
        if (got_cyc.size() >= 5) chk("t3_row_period", got_cyc[4] - got_cyc[0], PE + 2);
        chk("t3_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, k + 13 + CK);

        // stall pattern 1,0,0,1 while a second start arrives during the drain
        clear_mon();
        exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
        add_cksum();
        pulse_start(8'd1, 9'd1, k);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'd5; row_count = 9'd3;
        @(posedge clk); #1;
        start = 1'b0; m_if.m_ready = 1'b1;
        @(posedge clk); #1 m_if.m_ready = 1'b0;
        @(posedge clk); #1 m_if.m_ready = 1'b0;
        @(posedge clk); #1 m_if.m_ready = 1'b1;
        wait_done("t4", 40);
        check_stream("t4");
        chk("t4_nstall", stall_dat.size(), 2);
        foreach (stall_dat[i]) chk("t4_stall_hold", stall_dat[i], 32'h22);
        if (got_cyc.size() >= 2) chk("t4_cyc1", got_cyc[1], k + 6);
        chk("t4_done_cyc", (done_cyc.size() > 0) ? done_cyc[0] : -1, k + 9 + CK);
        repeat (6) @(posedge clk); #1;
        chk("t4_nreads", got_addr.size(), 1);
        chk("t4_still_idle", busy, 1'b0);

        // reset in the middle of row 1 of 3, with start asserted in the same cycle
        clear_mon();
        pulse_start(8'd10, 9'd3, k);
        repeat (4) @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; base_addr = 8'd20; row_count = 9'd1;
        m_if.m_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; m_if.m_ready = 1'b1;
        @(negedge clk);
        chk("t5_m_valid", m_if.m_valid, 1'b0);
        chk("t5_busy",    busy,         1'b0);
        chk("t5_rd_en",   rd_en,        1'b0);
        repeat (5) @(posedge clk); #1;
        chk("t5_partial_words", got_dat.size(), 2);
        chk("t5_partial_reads", got_addr.size(), 1);
        clear_mon();
        exp_q = '{32'd201, 32'd202, 32'd203, 32'd204};
        add_cksum();
        pulse_start(8'd20, 9'd1, k);
        wait_done("t5", 40);
        check_stream("t5");
        if (got_addr.size() > 0) chk("t5_addr", got_addr[0], 8'd20);

        // two rows 1..8: data words, plus the sum word 36 when the checksum is built in
        clear_mon();
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        add_cksum();
        pulse_start(8'd30, 9'd2, k);
        wait_done("t6", 60);
        check_stream("t6");
`ifdef RESULT_DRAIN_CHECKSUM_EN
        if (got_dat.size() == 9) begin
            chk("t6_sum",      got_dat[8],  32'd36);
            chk("t6_sum_last", got_last[8], 1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
